mem_irq_responder: RTL

MEM_IRQ_RESPONDER -- requirements
Module: mem_irq_responder

---
 rtl/mem_irq_responder_if.sv | 13 +
 rtl/mem_irq_responder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mem_irq_responder_if.sv
// CPU-side bus bundle for mem_irq_responder: address/strobes in, interrupt and error status out.
// The shared data bus stays a plain inout port on the responder so tristate resolution is explicit.
interface mem_irq_responder_if;
  logic [31:0] Addr;
  logic        Memread;
  logic [1:0]  Memwrite;
  logic        INTin;
  logic [31:0] INTnum;
  logic        bus_err;

  modport master (output Addr, Memread, Memwrite, input INTin, INTnum, bus_err);
  modport slave  (input Addr, Memread, Memwrite, output INTin, INTnum, bus_err);
endinterface

// File: rtl/mem_irq_responder.sv
// Memory-mapped RAM plus interrupt controller with a reloadable down-counting timer.
// Combinational reads onto a shared tristate bus; writes, pending bits and interrupts update on clk.
module mem_irq_responder #(
  parameter int DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_irq_responder_if.slave   cpu,
  inout  wire  [31:0]          BUS,
  input  logic [3:0]           irq_in
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {T_IDLE, T_RUN} tstate_t;

  logic [31:0]   r_mem [DEPTH];
  logic [4:0]    r_pend, r_mask;
  logic [31:0]   r_tload, r_tcount;
  tstate_t       r_tstate;
  logic [3:0]    r_sync1, r_sync2, r_sync3;
  logic          r_int, r_bus_err;
  logic [31:0]   r_int_num;

  logic          w_is_reg, w_rd_en, w_wr_word, w_wr_byte, w_wr_ok, w_reg_wr;
  logic [AW-1:0] w_idx;
  logic [7:0]    w_off;
  logic [31:0]   w_rdata, w_tcount_nxt, w_int_num;
  logic          w_tfire, w_err_evt;
  tstate_t       w_tstate_nxt;
  logic [4:0]    w_pend_set, w_ack_clr, w_active;
  logic [3:0]    w_edge;

  assign w_is_reg  = (cpu.Addr[31:8] == 24'hFFFFFF);
  assign w_off     = cpu.Addr[7:0];
  assign w_idx     = cpu.Addr[AW+1:2];
  assign w_wr_ok   = ~rst;
  assign w_wr_word = (cpu.Memwrite == 2'd1);
  assign w_wr_byte = (cpu.Memwrite == 2'd3);
  assign w_reg_wr  = w_wr_word && w_is_reg;
  assign w_rd_en   = ~rst && cpu.Memread && (cpu.Memwrite == 2'd0);
  assign w_err_evt = (cpu.Memwrite == 2'd2) || (cpu.Memread && (cpu.Memwrite != 2'd0));

  assign BUS = w_rd_en ? w_rdata : 'z;

  // NOTE: the RAM array has no reset branch so it maps onto a plain block RAM;
  // writes are instead suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (w_wr_ok && !w_is_reg) begin
      if (w_wr_word)      r_mem[w_idx]      <= BUS;
      else if (w_wr_byte) r_mem[w_idx][7:0] <= BUS[7:0];
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_rdata = '0;
    if (w_is_reg) begin
      case (w_off)
        8'h00:   w_rdata = {27'b0, r_pend};
        8'h04:   w_rdata = {27'b0, r_mask};
        8'h0C:   w_rdata = r_tload;
        8'h10:   w_rdata = r_tcount;
        8'h14:   w_rdata = {31'b0, r_tstate == T_RUN};
        default: w_rdata = '0;
      endcase
    end else begin
      w_rdata = r_mem[w_idx];
    end
  end

  // Timer FSM: state register, next-state logic, then count/fire outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tstate <= T_IDLE;
    else     r_tstate <= w_tstate_nxt;
  end

  always_comb begin
    w_tstate_nxt = r_tstate;
    if (w_reg_wr && w_off == 8'h14) w_tstate_nxt = BUS[0] ? T_RUN : T_IDLE;
  end

  always_comb begin
    w_tfire      = (r_tstate == T_RUN) && (r_tcount == 32'd0);
    w_tcount_nxt = r_tcount;
    if (w_reg_wr && w_off == 8'h0C)
      w_tcount_nxt = BUS;
    else if (r_tstate == T_IDLE && w_tstate_nxt == T_RUN)
      w_tcount_nxt = r_tload;
    else if (r_tstate == T_RUN)
      w_tcount_nxt = (r_tcount == 32'd0) ? r_tload : r_tcount - 32'd1;
  end

  assign w_edge     = r_sync2 & ~r_sync3;
  assign w_pend_set = {w_edge, w_tfire};
  assign w_ack_clr  = (w_reg_wr && w_off == 8'h08) ? BUS[4:0] : 5'b0;
  assign w_active   = r_pend & r_mask;

  // Lowest active source wins the cause code.
  always_comb begin
    w_int_num = '0;
    for (int k = 4; k >= 0; k--)
      if (w_active[k]) w_int_num = 32'(16 + k);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (rst) begin
      r_pend    <= '0;
      r_mask    <= '0;
      r_tload   <= '0;
      r_tcount  <= '0;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_sync3   <= '0;
      r_int     <= 1'b0;
      r_int_num <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_sync1   <= irq_in;
      r_sync2   <= r_sync1;
      r_sync3   <= r_sync2;
      r_pend    <= (r_pend & ~w_ack_clr) | w_pend_set;
      if (w_reg_wr && w_off == 8'h04) r_mask  <= BUS[4:0];
      if (w_reg_wr && w_off == 8'h0C) r_tload <= BUS;
      r_tcount  <= w_tcount_nxt;
      r_int     <= |w_active;
      r_int_num <= w_int_num;
      r_bus_err <= r_bus_err | w_err_evt;
    end
  end

  assign cpu.INTin   = r_int;
  assign cpu.INTnum  = r_int_num;
  assign cpu.bus_err = r_bus_err;

endmodule
